// File: rtl/mul_sequencer.sv
// Issue-side controller for the registered 1-cycle 33x33 multiplier used by the M-extension.
// Forms signed/unsigned operands, selects the result word and caches the last product.
module mul_sequencer #(
    parameter int unsigned TAG_W    = 5,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_flush,
    output logic [32:0]      o_mul_operand_a,
    output logic [32:0]      o_mul_operand_b,
    output logic             o_mul_valid,
    input  logic [63:0]      i_mul_product,
    input  logic             i_mul_valid,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;

    state_e             state_q;
    logic [1:0]         pend_op_q;
    logic [TAG_W-1:0]   pend_tag_q;
    logic [32:0]        pend_a_q;
    logic [32:0]        pend_b_q;
    logic               cache_valid_q;
    logic [32:0]        cache_a_q;
    logic [32:0]        cache_b_q;
    logic [63:0]        cache_product_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    logic [32:0]        op_a;
    logic [32:0]        op_b;
    logic               hit;
    logic               accept;

    always_comb begin
        op_a = {1'b0, i_rs1};
        op_b = {1'b0, i_rs2};
        case (i_req_op)
            OpMulh: begin
                op_a = {i_rs1[31], i_rs1};
                op_b = {i_rs2[31], i_rs2};
            end
            OpMulhsu: op_a = {i_rs1[31], i_rs1};
            default: ;
        endcase
    end

    function automatic logic [31:0] sel_word(input logic [1:0] op, input logic [63:0] p);
        return (op == OpMul) ? p[31:0] : p[63:32];
    endfunction

    // Op code is deliberately not part of the key: MUL/MULHU on the same registers share a product.
    assign hit = CACHE_EN && cache_valid_q && (op_a == cache_a_q) && (op_b == cache_b_q);

    assign o_req_ready     = (state_q == StIdle) && !i_flush && !i_rst;
    assign accept          = i_req_valid && o_req_ready;
    assign o_mul_valid     = accept && !hit;
    assign o_mul_operand_a = op_a;
    assign o_mul_operand_b = op_b;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_data      = rsp_data_q;
    assign o_rsp_tag       = rsp_tag_q;
    assign o_busy          = (state_q != StIdle);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (hit) begin
                            rsp_data_q  <= sel_word(i_req_op, cache_product_q);
                            rsp_tag_q   <= i_req_tag;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            pend_op_q  <= i_req_op;
                            pend_tag_q <= i_req_tag;
                            pend_a_q   <= op_a;
                            pend_b_q   <= op_b;
                            state_q    <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Flush wins over a same-cycle product: nothing returned, cache untouched.
                    if (i_flush) begin
                        state_q <= StIdle;
                    end else if (i_mul_valid) begin
                        rsp_data_q      <= sel_word(pend_op_q, i_mul_product);
                        rsp_tag_q       <= pend_tag_q;
                        rsp_valid_q     <= 1'b1;
                        cache_a_q       <= pend_a_q;
                        cache_b_q       <= pend_b_q;
                        cache_product_q <= i_mul_product;
                        cache_valid_q   <= 1'b1;
                        state_q         <= StResp;
                    end
                end
                StResp: begin
                    if (i_flush || i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
